// File: rtl/mult_div_unit_if.sv
// Pipeline <-> multiply/divide unit bus.
//   master (pipeline): drives start, op, inA, inB; reads busy, done, hi, lo, div_by_zero.
//   slave  (unit):     the reverse.
// op encoding: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
interface mult_div_unit_if #(
  parameter int unsigned N = 32
) ();
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_by_zero;

  modport master (
    output start, op, inA, inB,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, inA, inB,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative N-bit multiply/divide unit (MIPS MULT/MULTU/DIV/DIVU).
// Radix-2 shift-add multiply and restoring divide, one result bit per cycle.
// Fixed latency of N+1 cycles from the accepting edge to done.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mult_div_unit_if.slave: start/op/inA/inB in; busy/done/hi/lo/div_by_zero out
//
// Build option: define MDU_SIGNED_EN to enable MULT/DIV sign handling. Without it,
// op[0] is ignored and ops 1/3 behave as MULTU/DIVU.
module mult_div_unit #(
  parameter int unsigned N = 32
) (
  input logic           clock,
  input logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Multiply: {upper, multiplier}. Divide: {remainder, quotient}.
  logic [2*N-1:0] acc_q, acc_d;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [N-1:0]   opd_q, opd_d;
  logic [N-1:0]   a_q, a_d;
  logic           is_div_q, is_div_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           dbz_q, dbz_d;
  logic           done_q, done_d;

  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;

`ifdef MDU_SIGNED_EN
  logic signed_op;
  logic neg_q, neg_d;
  logic neg_rem_q, neg_rem_d;

  assign signed_op = bus.op[0];
  assign a_mag     = (signed_op && bus.inA[N-1]) ? -bus.inA : bus.inA;
  assign b_mag     = (signed_op && bus.inB[N-1]) ? -bus.inB : bus.inB;
  assign prod      = neg_q ? -acc_q : acc_q;
  assign quo       = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem       = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
`else
  logic unused_op0;

  assign unused_op0 = bus.op[0];
  assign a_mag      = bus.inA;
  assign b_mag      = bus.inB;
  assign prod       = acc_q;
  assign quo        = acc_q[N-1:0];
  assign rem        = acc_q[2*N-1:N];
`endif

  // Multiply step: conditional add into an N+1-bit upper half, then shift right.
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_step = {mul_sum, acc_q[N-1:1]};

  // Divide step: shift {rem, quo} left, trial-subtract divisor from the N+1-bit remainder.
  logic [N:0]     div_shift, div_diff;
  logic [2*N-1:0] div_step;
  assign div_shift = acc_q[2*N-1:N-1];
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_step  = div_diff[N] ? {acc_q[2*N-2:0], 1'b0}
                                 : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
`ifdef MDU_SIGNED_EN
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          a_d      = bus.inA;
          zero_d   = (bus.inB == '0);
          acc_d    = {{N{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          opd_d    = bus.op[1] ? b_mag : a_mag;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          state_d  = StRun;
`ifdef MDU_SIGNED_EN
          neg_d     = signed_op && (bus.inA[N-1] ^ bus.inB[N-1]);
          neg_rem_d = signed_op && bus.inA[N-1];
`endif
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (zero_q) begin
          // Divide by zero: quotient all ones, remainder is the raw dividend.
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

`ifdef MDU_SIGNED_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
